cmsdk_ahb_slave_mux: RTL and testbench

CMSDK_AHB_SLAVE_MUX -- requirements
Module: cmsdk_ahb_slave_mux

---
 rtl/cmsdk_ahb_slave_mux.sv | 128 ++++++++++++
 tb/tb_cmsdk_ahb_slave_mux.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmsdk_ahb_slave_mux.sv
// AHB-Lite slave multiplexer for up to ten slaves: registers the address-phase
// selects and steers ready, response and read data back during the data phase.
module cmsdk_ahb_slave_mux #(
    parameter bit PORT0_ENABLE = 1'b1,
    parameter bit PORT1_ENABLE = 1'b1,
    parameter bit PORT2_ENABLE = 1'b1,
    parameter bit PORT3_ENABLE = 1'b1,
    parameter bit PORT4_ENABLE = 1'b1,
    parameter bit PORT5_ENABLE = 1'b1,
    parameter bit PORT6_ENABLE = 1'b1,
    parameter bit PORT7_ENABLE = 1'b1,
    parameter bit PORT8_ENABLE = 1'b1,
    parameter bit PORT9_ENABLE = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HREADY,
    input  logic        HSEL0,
    input  logic        HSEL1,
    input  logic        HSEL2,
    input  logic        HSEL3,
    input  logic        HSEL4,
    input  logic        HSEL5,
    input  logic        HSEL6,
    input  logic        HSEL7,
    input  logic        HSEL8,
    input  logic        HSEL9,
    input  logic        HREADYOUT0,
    input  logic        HREADYOUT1,
    input  logic        HREADYOUT2,
    input  logic        HREADYOUT3,
    input  logic        HREADYOUT4,
    input  logic        HREADYOUT5,
    input  logic        HREADYOUT6,
    input  logic        HREADYOUT7,
    input  logic        HREADYOUT8,
    input  logic        HREADYOUT9,
    input  logic        HRESP0,
    input  logic        HRESP1,
    input  logic        HRESP2,
    input  logic        HRESP3,
    input  logic        HRESP4,
    input  logic        HRESP5,
    input  logic        HRESP6,
    input  logic        HRESP7,
    input  logic        HRESP8,
    input  logic        HRESP9,
    input  logic [31:0] HRDATA0,
    input  logic [31:0] HRDATA1,
    input  logic [31:0] HRDATA2,
    input  logic [31:0] HRDATA3,
    input  logic [31:0] HRDATA4,
    input  logic [31:0] HRDATA5,
    input  logic [31:0] HRDATA6,
    input  logic [31:0] HRDATA7,
    input  logic [31:0] HRDATA8,
    input  logic [31:0] HRDATA9,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int NPORTS = 10;

    // Absent ports are masked at both the register input and the output side,
    // so their inputs can never influence the bus.
    localparam logic [NPORTS-1:0] PORT_EN = {PORT9_ENABLE, PORT8_ENABLE, PORT7_ENABLE,
                                             PORT6_ENABLE, PORT5_ENABLE, PORT4_ENABLE,
                                             PORT3_ENABLE, PORT2_ENABLE, PORT1_ENABLE,
                                             PORT0_ENABLE};

    logic [NPORTS-1:0] hsel_s;
    logic [NPORTS-1:0] hreadyout_s;
    logic [NPORTS-1:0] hresp_s;
    logic [31:0]       hrdata_s [NPORTS];
    logic [NPORTS-1:0] reg_sel_r;
    logic [NPORTS-1:0] sel_s;
    logic              ready_or_s;
    logic              resp_or_s;
    logic [31:0]       rdata_or_s;

    assign hsel_s      = {HSEL9, HSEL8, HSEL7, HSEL6, HSEL5, HSEL4, HSEL3, HSEL2, HSEL1, HSEL0};
    assign hreadyout_s = {HREADYOUT9, HREADYOUT8, HREADYOUT7, HREADYOUT6, HREADYOUT5,
                          HREADYOUT4, HREADYOUT3, HREADYOUT2, HREADYOUT1, HREADYOUT0};
    assign hresp_s     = {HRESP9, HRESP8, HRESP7, HRESP6, HRESP5,
                          HRESP4, HRESP3, HRESP2, HRESP1, HRESP0};
    assign hrdata_s[0] = HRDATA0;
    assign hrdata_s[1] = HRDATA1;
    assign hrdata_s[2] = HRDATA2;
    assign hrdata_s[3] = HRDATA3;
    assign hrdata_s[4] = HRDATA4;
    assign hrdata_s[5] = HRDATA5;
    assign hrdata_s[6] = HRDATA6;
    assign hrdata_s[7] = HRDATA7;
    assign hrdata_s[8] = HRDATA8;
    assign hrdata_s[9] = HRDATA9;

    // Data-phase select register: advances only on an accepted address phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            reg_sel_r <= {NPORTS{1'b0}};
        end else if (HREADY) begin
            reg_sel_r <= hsel_s & PORT_EN;
        end else begin
            reg_sel_r <= reg_sel_r;
        end
    end

    assign sel_s = reg_sel_r & PORT_EN;

    // AND-OR steering; several selects at once simply OR together, no priority.
    always_comb begin
        ready_or_s = 1'b0;
        resp_or_s  = 1'b0;
        rdata_or_s = 32'h0000_0000;
        for (int i = 0; i < NPORTS; i++) begin
            ready_or_s = ready_or_s | (sel_s[i] & hreadyout_s[i]);
            resp_or_s  = resp_or_s  | (sel_s[i] & hresp_s[i]);
            rdata_or_s = rdata_or_s | ({32{sel_s[i]}} & hrdata_s[i]);
        end
    end

    // Idle (nothing selected in data phase) reports ready.
    assign HREADYOUT = ready_or_s | ~(|sel_s);
    assign HRESP     = resp_or_s;
    assign HRDATA    = rdata_or_s;

endmodule

// File: tb/tb_cmsdk_ahb_slave_mux.sv
// Self-checking bench for cmsdk_ahb_slave_mux with port 2 absent; directed
// scenarios plus randomized traffic checked against a transaction-level model.
module tb_cmsdk_ahb_slave_mux;

    localparam logic [9:0] EN_MASK = 10'b11_1111_1011;

    logic        HCLK;
    logic        HRESETn;
    logic        HREADY;
    logic [9:0]  hsel;
    logic [9:0]  hrdy;
    logic [9:0]  hresp;
    logic [31:0] hrdata [10];
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    int checks;
    int errors;

    // Model state: the set of slaves that own the current data phase.
    logic [9:0] owners;

    cmsdk_ahb_slave_mux #(.PORT2_ENABLE(1'b0)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HREADY(HREADY),
        .HSEL0(hsel[0]), .HSEL1(hsel[1]), .HSEL2(hsel[2]), .HSEL3(hsel[3]), .HSEL4(hsel[4]),
        .HSEL5(hsel[5]), .HSEL6(hsel[6]), .HSEL7(hsel[7]), .HSEL8(hsel[8]), .HSEL9(hsel[9]),
        .HREADYOUT0(hrdy[0]), .HREADYOUT1(hrdy[1]), .HREADYOUT2(hrdy[2]), .HREADYOUT3(hrdy[3]),
        .HREADYOUT4(hrdy[4]), .HREADYOUT5(hrdy[5]), .HREADYOUT6(hrdy[6]), .HREADYOUT7(hrdy[7]),
        .HREADYOUT8(hrdy[8]), .HREADYOUT9(hrdy[9]),
        .HRESP0(hresp[0]), .HRESP1(hresp[1]), .HRESP2(hresp[2]), .HRESP3(hresp[3]),
        .HRESP4(hresp[4]), .HRESP5(hresp[5]), .HRESP6(hresp[6]), .HRESP7(hresp[7]),
        .HRESP8(hresp[8]), .HRESP9(hresp[9]),
        .HRDATA0(hrdata[0]), .HRDATA1(hrdata[1]), .HRDATA2(hrdata[2]), .HRDATA3(hrdata[3]),
        .HRDATA4(hrdata[4]), .HRDATA5(hrdata[5]), .HRDATA6(hrdata[6]), .HRDATA7(hrdata[7]),
        .HRDATA8(hrdata[8]), .HRDATA9(hrdata[9]),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // An address phase accepted while out of reset hands the data phase to the
    // present slaves that were addressed; reset forgets any owner.
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) owners <= 10'b0;
        else if (HREADY) owners <= hsel & EN_MASK;
    end

    // Expected {HREADYOUT, HRESP, HRDATA} from the owners and what they drive.
    function automatic logic [33:0] expect_bus();
        logic        rdy;
        logic        rsp;
        logic [31:0] dat;
        rdy = (owners == 10'b0);
        rsp = 1'b0;
        dat = 32'h0;
        for (int i = 0; i < 10; i++) begin
            if (owners[i]) begin
                rdy = rdy | hrdy[i];
                rsp = rsp | hresp[i];
                dat = dat | hrdata[i];
            end
        end
        return {rdy, rsp, dat};
    endfunction

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic randomize_slaves();
        for (int i = 0; i < 10; i++) begin
            hrdata[i] = $urandom;
            hrdy[i]   = 1'($urandom_range(0, 1));
            hresp[i]  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle_slaves();
        for (int i = 0; i < 10; i++) begin
            hrdata[i] = 32'h0;
            hrdy[i]   = 1'b1;
            hresp[i]  = 1'b0;
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        HREADY  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            hsel = 10'($urandom);
            randomize_slaves();
            #1;
            checks++;
            if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
                errors++;
                $display("FAIL reset: got %h expected %h", {HREADYOUT, HRESP, HRDATA}, {1'b1, 1'b0, 32'h0});
            end
            step();
        end
        hsel = 10'b0;
        idle_slaves();
        HRESETn = 1'b1;
        step();
    endtask

    task automatic test_read_port0();
        hsel   = 10'b00_0000_0001;
        HREADY = 1'b1;
        step();
        hsel      = 10'b0;
        hrdata[0] = 32'h1234_5678;
        hrdy[0]   = 1'b1;
        hresp[0]  = 1'b0;
        #1;
        checks++;
        if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h1234_5678}) begin
            errors++;
            $display("FAIL read_port0: got %h expected %h", {HREADYOUT, HRESP, HRDATA}, {1'b1, 1'b0, 32'h1234_5678});
        end
        step();
        idle_slaves();
    endtask

    task automatic test_wait_error();
        logic [3:0] rdy_seq;
        logic [3:0] rsp_seq;
        rdy_seq = 4'b1000;  // cycle 0 in bit 0
        rsp_seq = 4'b1100;
        hsel   = 10'b00_0000_0010;
        HREADY = 1'b1;
        step();
        hsel = 10'b00_0000_0001;  // pending next address, must not steal the data phase
        for (int c = 0; c < 4; c++) begin
            hrdy[1]   = rdy_seq[c];
            hresp[1]  = rsp_seq[c];
            hrdata[1] = $urandom;
            hrdy[0]   = 1'b1;
            hrdata[0] = 32'hBAD0_0000;
            HREADY    = rdy_seq[c];
            #1;
            checks++;
            if ({HREADYOUT, HRESP} !== {rdy_seq[c], rsp_seq[c]} || HRDATA !== hrdata[1]) begin
                errors++;
                $display("FAIL wait_error[%0d]: got %h expected %h", c, {HREADYOUT, HRESP, HRDATA},
                         {rdy_seq[c], rsp_seq[c], hrdata[1]});
            end
            step();
        end
        hsel   = 10'b0;
        HREADY = 1'b1;
        idle_slaves();
        step();
    endtask

    task automatic test_back_to_back();
        hsel   = 10'b00_0000_0001;
        HREADY = 1'b1;
        step();
        hsel      = 10'b00_0000_0010;
        hrdata[0] = 32'hAAAA_5555;
        hrdata[1] = 32'h1111_1111;
        #1;
        checks++;
        if (HRDATA !== 32'hAAAA_5555 || HREADYOUT !== 1'b1) begin
            errors++;
            $display("FAIL b2b_port0: got %h/%b expected aaaa5555/1", HRDATA, HREADYOUT);
        end
        step();
        hsel      = 10'b0;
        hrdata[1] = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (HRDATA !== 32'hDEAD_BEEF || HREADYOUT !== 1'b1) begin
            errors++;
            $display("FAIL b2b_port1: got %h/%b expected deadbeef/1", HRDATA, HREADYOUT);
        end
        step();
        hrdata[0] = $urandom;
        hrdata[1] = $urandom;
        hrdy[0]   = 1'b0;
        hresp[1]  = 1'b1;
        #1;
        checks++;
        if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL b2b_idle: got %h expected %h", {HREADYOUT, HRESP, HRDATA}, {1'b1, 1'b0, 32'h0});
        end
        idle_slaves();
    endtask

    task automatic test_disabled_port();
        hsel   = 10'b00_0000_0100;
        HREADY = 1'b1;
        step();
        hrdata[2] = 32'hFFFF_FFFF;
        hrdy[2]   = 1'b0;
        hresp[2]  = 1'b1;
        #1;
        checks++;
        if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL disabled_port: got %h expected %h", {HREADYOUT, HRESP, HRDATA}, {1'b1, 1'b0, 32'h0});
        end
        hsel = 10'b0;
        step();
        idle_slaves();
    endtask

    task automatic test_reset_mid_wait();
        hsel   = 10'b00_0000_0001;
        HREADY = 1'b1;
        step();
        hsel      = 10'b0;
        hrdy[0]   = 1'b0;
        hresp[0]  = 1'b1;
        hrdata[0] = 32'hCAFE_F00D;
        HREADY    = 1'b0;
        #1;
        checks++;
        if ({HREADYOUT, HRESP, HRDATA} !== {1'b0, 1'b1, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL mid_wait_pre: got %h expected %h", {HREADYOUT, HRESP, HRDATA}, {1'b0, 1'b1, 32'hCAFE_F00D});
        end
        HRESETn = 1'b0;
        #1;
        checks++;
        if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL mid_wait_reset: got %h expected %h", {HREADYOUT, HRESP, HRDATA}, {1'b1, 1'b0, 32'h0});
        end
        step();
        HRESETn = 1'b1;
        HREADY  = 1'b1;
        #1;
        checks++;
        if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL mid_wait_release: got %h expected %h", {HREADYOUT, HRESP, HRDATA}, {1'b1, 1'b0, 32'h0});
        end
        idle_slaves();
        step();
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      hsel = 10'b0;
            else if (r < 8) hsel = 10'b1 << $urandom_range(0, 9);
            else            hsel = 10'($urandom);
            HREADY = ($urandom_range(0, 3) != 0);
            randomize_slaves();
            #1;
            checks++;
            if ({HREADYOUT, HRESP, HRDATA} !== expect_bus()) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h owners %b", c,
                         {HREADYOUT, HRESP, HRDATA}, expect_bus(), owners);
            end
            step();
        end
        hsel   = 10'b0;
        HREADY = 1'b1;
        step();
        idle_slaves();
        #1;
        checks++;
        if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL random_idle: got %h expected %h", {HREADYOUT, HRESP, HRDATA}, {1'b1, 1'b0, 32'h0});
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        HRESETn = 1'b0;
        HREADY  = 1'b1;
        hsel    = 10'b0;
        idle_slaves();
        #2;
        test_reset();
        test_read_port0();
        test_wait_error();
        test_back_to_back();
        test_disabled_port();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
